// File: rtl/stream_mux_rr_pkg.sv
`default_nettype none
// ============================================================================
// stream_mux_rr_pkg : index helpers shared by the stream mux and its arbiter
// Rev 1.0
// ============================================================================
package stream_mux_rr_pkg;

  // Fold an index from the doubled scan range back into 0..n-1.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? (i - n) : i;
  endfunction

  // Round-robin pointer successor: one past the granted channel, wrapping.
  function automatic int rr_next(input int g, input int n);
    return (g == n - 1) ? 0 : (g + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_rr_select.sv
`default_nettype none
// ============================================================================
// rr_select : combinational round-robin grant, first valid at/after pointer
// Rev 1.0
// ============================================================================
module rr_select
  import stream_mux_rr_pkg::*;
#(
  parameter  int NumInp   = 4,
  localparam int IdxWidth = $clog2(NumInp)
) (
  input  logic [NumInp-1:0]   i_valid,
  input  logic [IdxWidth-1:0] i_ptr,
  output logic [IdxWidth-1:0] o_gnt_idx,
  output logic                o_gnt_vld
);

  logic [2*NumInp-1:0] w_dbl;

  assign w_dbl = {i_valid, i_valid};

  // Descending scan over the window [ptr, ptr+NumInp) so the lowest hit wins.
  always_comb begin
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    for (int i = 2*NumInp-1; i >= 0; i--) begin
      if (w_dbl[i] && (i >= int'(i_ptr)) && (i < int'(i_ptr) + NumInp)) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = IdxWidth'(wrap_idx(i, NumInp));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// stream_mux_rr : registered N:1 valid/ready mux, round-robin or external select
// Rev 1.0
// ============================================================================
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int NumInp   = 4,
  parameter  int Width    = 8,
  parameter  bit ExtSel   = 1'b0,
  localparam int IdxWidth = $clog2(NumInp)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumInp*Width-1:0] inp_data_i,
  input  logic [NumInp-1:0]       inp_valid_i,
  output logic [NumInp-1:0]       inp_ready_o,
  input  logic [IdxWidth-1:0]     sel_i,
  output logic [Width-1:0]        oup_data_o,
  output logic [IdxWidth-1:0]     oup_idx_o,
  output logic                    oup_valid_o,
  input  logic                    oup_ready_i
);

  logic                r_valid;
  logic [Width-1:0]    r_data;
  logic [IdxWidth-1:0] r_idx;
  logic                w_load;
  logic                w_hs;
  logic                w_gnt_vld;
  logic [IdxWidth-1:0] w_gnt_idx;
  logic [Width-1:0]    w_gnt_data;
  logic [NumInp-1:0]   w_gnt_onehot;

  assign w_load = !r_valid || oup_ready_i;
  assign w_hs   = w_gnt_vld && w_load;

  generate
    if (ExtSel) begin : g_ext
      logic [NumInp-1:0] w_sel_onehot;
      // Out-of-range selects shift the bit off the top, giving no grant.
      assign w_sel_onehot = {{(NumInp-1){1'b0}}, 1'b1} << sel_i;
      assign w_gnt_vld    = |(inp_valid_i & w_sel_onehot);
      assign w_gnt_idx    = sel_i;
    end else begin : g_rr
      logic [IdxWidth-1:0] r_rr_q;
      logic                w_unused_sel;

      assign w_unused_sel = ^sel_i;

      rr_select #(.NumInp(NumInp)) u_rr_select (
        .i_valid   (inp_valid_i),
        .i_ptr     (r_rr_q),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
      );

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_rr_q <= '0;
        end else if (w_hs) begin
          r_rr_q <= IdxWidth'(rr_next(int'(w_gnt_idx), NumInp));
        end
      end
    end
  endgenerate

  assign w_gnt_data   = inp_data_i[int'(w_gnt_idx)*Width +: Width];
  assign w_gnt_onehot = {{(NumInp-1){1'b0}}, 1'b1} << w_gnt_idx;
  assign inp_ready_o  = w_hs ? w_gnt_onehot : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
    end else if (w_hs) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_idx   <= w_gnt_idx;
    end else if (oup_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign oup_valid_o = r_valid;
  assign oup_data_o  = r_data;
  assign oup_idx_o   = r_idx;

endmodule
`default_nettype wire
